// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared FSM state type and default timing constants
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } btn_state_t;

   localparam int SYNC_STAGES_DEF     = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int REPEAT_CYCLES_DEF   = 25000000;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizer, debounce FSM, level and press pulse for one button
// AUTO_REPEAT_EN adds a held-press repeat pulse on instances with REPEAT=1.
module button_debounce
   import button_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
   parameter bit REPEAT          = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_btn;
   btn_state_t             state, state_next;
   logic [CNT_W-1:0]       cnt, cnt_next;
   logic                   level_next;
   logic                   press_next;
   logic                   repeat_pulse;

   // Buttons idle high, so the chain resets to 1 to avoid a false press on release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign sync_btn = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         level <= 1'b1;
         pulse <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         level <= level_next;
         pulse <= press_next | repeat_pulse;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      press_next = 1'b0;
      case (state)
         IDLE: begin
            if (!sync_btn) begin
               state_next = PRESS_WAIT;
               cnt_next   = '0;
            end
         end
         PRESS_WAIT: begin
            if (sync_btn) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = PRESSED;
               cnt_next   = '0;
               press_next = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (sync_btn) begin
               state_next = RELEASE_WAIT;
               cnt_next   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!sync_btn) begin
               state_next = PRESSED;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      level_next = !((state_next == PRESSED) || (state_next == RELEASE_WAIT));
   end

`ifdef AUTO_REPEAT_EN
   generate
      if (REPEAT) begin : g_repeat
         localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
         localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
         logic [RPT_W-1:0] rpt_cnt;
         logic             holding;

         assign holding      = (state == PRESSED) && (state_next == PRESSED);
         assign repeat_pulse = holding && (rpt_cnt == RPT_LAST);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rpt_cnt <= '0;
            end else if (holding && (rpt_cnt != RPT_LAST)) begin
               rpt_cnt <= rpt_cnt + RPT_W'(1);
            end else begin
               rpt_cnt <= '0;
            end
         end
      end else begin : g_no_repeat
         assign repeat_pulse = 1'b0;
      end
   endgenerate
`else
   logic unused_repeat;
   assign unused_repeat = REPEAT && (REPEAT_CYCLES > 0);
   assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - syncs and debounces three active-low buttons, syncs 8 switches
// AUTO_REPEAT_EN enables held-press auto-repeat on Run.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       LoadB_raw,
   input  logic       Run_raw,
   input  logic       ClearA_LoadB_raw,
   input  logic [7:0] SW_raw,
   output logic       LoadB,
   output logic       Run,
   output logic       ClearA_LoadB,
   output logic       LoadB_pulse,
   output logic       Run_pulse,
   output logic       ClearA_LoadB_pulse,
   output logic [7:0] SW
);

   logic [SYNC_STAGES-1:0][7:0] sw_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sw_q <= '0;
      end else begin
         sw_q <= {sw_q[SYNC_STAGES-2:0], SW_raw};
      end
   end

   assign SW = sw_q[SYNC_STAGES-1];

   button_debounce #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W),
      .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT(1'b0)
   ) u_loadb (
      .clk(Clk), .rst_n(Reset), .raw(LoadB_raw), .level(LoadB), .pulse(LoadB_pulse)
   );

   button_debounce #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W),
      .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT(1'b1)
   ) u_run (
      .clk(Clk), .rst_n(Reset), .raw(Run_raw), .level(Run), .pulse(Run_pulse)
   );

   button_debounce #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W),
      .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT(1'b0)
   ) u_clear (
      .clk(Clk), .rst_n(Reset), .raw(ClearA_LoadB_raw), .level(ClearA_LoadB),
      .pulse(ClearA_LoadB_pulse)
   );

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
// Expected Run pulse count follows AUTO_REPEAT_EN.
module tb_button_conditioner;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       LoadB_raw, Run_raw, ClearA_LoadB_raw;
   logic [7:0] SW_raw;
   logic       LoadB, Run, ClearA_LoadB;
   logic       LoadB_pulse, Run_pulse, ClearA_LoadB_pulse;
   logic [7:0] SW;

   button_conditioner #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)
   ) dut (
      .Clk(Clk), .Reset(Reset),
      .LoadB_raw(LoadB_raw), .Run_raw(Run_raw), .ClearA_LoadB_raw(ClearA_LoadB_raw),
      .SW_raw(SW_raw),
      .LoadB(LoadB), .Run(Run), .ClearA_LoadB(ClearA_LoadB),
      .LoadB_pulse(LoadB_pulse), .Run_pulse(Run_pulse),
      .ClearA_LoadB_pulse(ClearA_LoadB_pulse),
      .SW(SW)
   );

   always #5 Clk = ~Clk;

   int edge_cnt = 0;
   always @(posedge Clk) edge_cnt <= edge_cnt + 1;

   // mask bit order: {ClearA_LoadB, Run, LoadB}
   typedef struct {
      int       cyc;
      logic [2:0] mask;
   } exp_t;
   exp_t sb[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   task automatic wait_until(input int target);
      while (edge_cnt < target) @(negedge Clk);
   endtask

   always @(negedge Clk) begin : monitor
      logic [2:0] m;
      exp_t       e;
      m = {ClearA_LoadB_pulse, Run_pulse, LoadB_pulse};
      if (m !== 3'b000) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {29'd0, m}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pulse_cycle", edge_cnt, e.cyc);
            check("pulse_mask", {29'd0, m}, {29'd0, e.mask});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int         e;
      int         r;
      logic [7:0] prev, v;

      // reset with random raw inputs
      Reset            = 1'b0;
      LoadB_raw        = 1'($urandom);
      Run_raw          = 1'($urandom);
      ClearA_LoadB_raw = 1'($urandom);
      SW_raw           = 8'($urandom);
      repeat (3) @(negedge Clk);
      check("rst_levels", {29'd0, LoadB, Run, ClearA_LoadB}, 32'h7);
      check("rst_pulses", {29'd0, LoadB_pulse, Run_pulse, ClearA_LoadB_pulse}, 32'h0);
      check("rst_sw", {24'd0, SW}, 32'h0);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      check("post_rst_levels", {29'd0, LoadB, Run, ClearA_LoadB}, 32'h7);
      check("post_rst_sw", {24'd0, SW}, {24'd0, SW_raw});
      prev = SW_raw;
      LoadB_raw = 1'b1; Run_raw = 1'b1; ClearA_LoadB_raw = 1'b1;
      repeat (10) @(negedge Clk);

      // clean Run press, held long enough for three repeat periods
      e = edge_cnt;
      Run_raw = 1'b0;
      sb.push_back('{e + 7, 3'b010});
`ifdef AUTO_REPEAT_EN
      sb.push_back('{e + 15, 3'b010});
      sb.push_back('{e + 23, 3'b010});
      sb.push_back('{e + 31, 3'b010});
`endif
      wait_until(e + 6);
      check("run_level_before", {31'd0, Run}, 32'd1);
      wait_until(e + 7);
      check("run_level_accept", {31'd0, Run}, 32'd0);
      wait_until(e + 35);
      check("run_level_held", {31'd0, Run}, 32'd0);
      r = edge_cnt;
      Run_raw = 1'b1;
      wait_until(r + 6);
      check("run_release_early", {31'd0, Run}, 32'd0);
      wait_until(r + 7);
      check("run_release", {31'd0, Run}, 32'd1);
      repeat (10) @(negedge Clk);

      // bounce shorter than the debounce window
      e = edge_cnt;
      LoadB_raw = 1'b0;
      wait_until(e + 3);
      LoadB_raw = 1'b1;
      wait_until(e + 6);
      check("bounce_level_mid", {31'd0, LoadB}, 32'd1);
      wait_until(e + 14);
      check("bounce_level_end", {31'd0, LoadB}, 32'd1);

      // full LoadB press, then one-cycle glitch during release
      e = edge_cnt;
      LoadB_raw = 1'b0;
      sb.push_back('{e + 7, 3'b001});
      wait_until(e + 10);
      check("loadb_level_pressed", {31'd0, LoadB}, 32'd0);
      r = edge_cnt;
      LoadB_raw = 1'b1;
      wait_until(r + 3);
      LoadB_raw = 1'b0;
      wait_until(r + 4);
      LoadB_raw = 1'b1;
      wait_until(r + 10);
      check("glitch_release_early", {31'd0, LoadB}, 32'd0);
      wait_until(r + 11);
      check("glitch_release", {31'd0, LoadB}, 32'd1);
      repeat (10) @(negedge Clk);

      // simultaneous LoadB and ClearA_LoadB
      e = edge_cnt;
      LoadB_raw = 1'b0;
      ClearA_LoadB_raw = 1'b0;
      sb.push_back('{e + 7, 3'b101});
      wait_until(e + 7);
      check("simul_levels", {29'd0, LoadB, Run, ClearA_LoadB}, 32'h2);
      LoadB_raw = 1'b1;
      ClearA_LoadB_raw = 1'b1;
      wait_until(e + 20);
      check("simul_released", {29'd0, LoadB, Run, ClearA_LoadB}, 32'h7);

      // reset in the middle of a debounce with the button still held
      e = edge_cnt;
      Run_raw = 1'b0;
      wait_until(e + 4);
      Reset = 1'b0;
      wait_until(e + 6);
      check("midrst_level_in_reset", {31'd0, Run}, 32'd1);
      Reset = 1'b1;
      sb.push_back('{e + 13, 3'b010});
      wait_until(e + 12);
      check("midrst_level_early", {31'd0, Run}, 32'd1);
      wait_until(e + 13);
      check("midrst_level_accept", {31'd0, Run}, 32'd0);
      Run_raw = 1'b1;
      repeat (12) @(negedge Clk);
      prev = SW;

      // switch synchronizer latency
      for (int i = 0; i < 4; i++) begin
         e = edge_cnt;
         v = prev ^ 8'($urandom_range(1, 255));
         SW_raw = v;
         wait_until(e + 1);
         check("sw_lat1", {24'd0, SW}, {24'd0, prev});
         wait_until(e + 2);
         check("sw_lat2", {24'd0, SW}, {24'd0, v});
         prev = v;
      end

      repeat (10) @(negedge Clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-conditioning stage that sits directly upstream of the multiplier top level.
- Takes raw active-low push-button signals and slider switches from the board pins. Synchronizes them to Clk and debounces each button.
- Delivers clean active-low button levels plus one-cycle active-high press pulses, so the downstream control sees exactly one event per physical press.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth for every input (minimum 2).
- DEBOUNCE_CYCLES, 1000000, cycles an input must hold stable before it is accepted (20 ms at 50 MHz).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width.
- REPEAT_CYCLES, 25000000, auto-repeat period for Run; used only when AUTO_REPEAT_EN is defined.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-low reset.
- LoadB_raw  in  1  raw push-button 1, active low.
- Run_raw  in  1  raw push-button 3, active low.
- ClearA_LoadB_raw  in  1  raw push-button 2, active low.
- SW_raw  in  8  raw slider switches.
- LoadB  out  1  debounced level, active low.
- Run  out  1  debounced level, active low.
- ClearA_LoadB  out  1  debounced level, active low.
- LoadB_pulse  out  1  one-cycle pulse on accepted press, active high.
- Run_pulse  out  1  one-cycle pulse on accepted press, active high.
- ClearA_LoadB_pulse  out  1  one-cycle pulse on accepted press, active high.
- SW  out  8  synchronized switches (not debounced).

Behaviour:
- Clock and reset:
  - One clock, Clk. Reset is asynchronous and active-low.
  - While Reset=0: button synchronizer flops are forced to 1, switch synchronizer flops to 0, every FSM goes to IDLE, and all counters clear.
  - Reset values of outputs: LoadB=Run=ClearA_LoadB=1; all *_pulse=0; SW=8'h00.
- Synchronization: each input passes through SYNC_STAGES flops; the last stage is the "sync" value.
- Per-button FSM; counter cnt is CNT_W bits, cleared on every state change:
  - IDLE: level=1. sync=0 -> PRESS_WAIT.
  - PRESS_WAIT: sync=1 -> IDLE (bounce rejected, no pulse). sync=0 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED. Otherwise cnt++.
  - PRESSED: level=0. sync=1 -> RELEASE_WAIT.
  - RELEASE_WAIT: sync=0 -> PRESSED (no new pulse). sync=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt++.
- Outputs and latency:
  - Level and pulse are registered. The level falls and the pulse rises on the same edge that enters PRESSED; the pulse clears on the next edge.
  - Latency, raw stable low -> pulse: SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges, counted from the first edge that samples raw low.
  - Release -> level=1: same latency.
- Boundary conditions:
  - Counter never wraps; it saturates by state exit.
  - Buttons are fully independent. Simultaneous presses each produce their own pulse on the same cycle.
  - Reset asserted mid-count or mid-press returns to IDLE with no pulse, including on reset release.
  - A button held low through reset release must complete a full debounce before it pulses.
- SW: synchronized only, latency SYNC_STAGES edges.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: for Run only, while in PRESSED, a second counter counts to REPEAT_CYCLES-1 and then emits one additional Run_pulse and restarts. The counter is cleared on leaving PRESSED.
- Undefined: no repeat counter is synthesized; exactly one Run_pulse per accepted press.

Decomposition:
- Package button_conditioner_pkg:
  - btn_state_t enum: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - Default constants for SYNC_STAGES, DEBOUNCE_CYCLES and REPEAT_CYCLES.
- Sub-module button_debounce: synchronizer, FSM, counter, level and pulse for one button. Instantiated three times.
- Switch synchronizers live inline in the top.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_CYCLES=8):
- Reset: Reset=0 with random raw inputs -> LoadB=Run=ClearA_LoadB=1, pulses 0, SW=00. Hold for 3 cycles after release -> outputs unchanged.
- Clean press: Run_raw falls before edge 1 and is held -> Run_pulse=1 exactly in the cycle after edge 7, 0 after edge 8, Run=0 from edge 7. Release -> Run=1 seven edges later, no pulse.
- Bounce: LoadB_raw low for 3 cycles, then high -> no LoadB_pulse, LoadB stays 1. Low 1 cycle during release -> no second pulse.
- Simultaneous: LoadB_raw and ClearA_LoadB_raw fall on the same cycle -> both pulses high in the same cycle. Run unaffected.
- Reset mid-debounce: Run_raw low, Reset=0 at edge 5 and released at edge 6, raw still low -> no pulse before edge 13; pulse on a full debounce after release.
- AUTO_REPEAT_EN defined, Run held 30 cycles past acceptance -> initial pulse plus one pulse every 8 cycles (3 extra). Undefined -> exactly 1 pulse.
